// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: finds word alignment from DVI control tokens,
// decodes 8-bit pixel data or 2-bit control and tracks lock status.
module tmds_channel_decoder #(
    parameter int C_LOCK_TOKENS  = 16,
    parameter int C_SEARCH_WORDS = 2048,
    parameter int C_LOSS_WORDS   = 4096
) (
    input  logic        clk_pixel,
    input  logic        rst_pixel,
    input  logic [9:0]  in_word,
    output logic [7:0]  out_data,
    output logic        out_de,
    output logic        out_c0,
    output logic        out_c1,
    output logic        out_locked,
    output logic [3:0]  out_offset,
    output logic [15:0] out_loss_count
);

    localparam int IDLE_MAX = (C_SEARCH_WORDS > C_LOSS_WORDS) ?
                              C_SEARCH_WORDS : C_LOSS_WORDS;
    localparam int IW = $clog2(IDLE_MAX + 1);
    localparam int RW = $clog2(C_LOCK_TOKENS + 1);

    localparam logic [IW-1:0] SEARCH_LAST = IW'(C_SEARCH_WORDS - 1);
    localparam logic [IW-1:0] LOSS_LAST   = IW'(C_LOSS_WORDS - 1);
    localparam logic [RW-1:0] LOCK_LAST   = RW'(C_LOCK_TOKENS - 1);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [9:0]     prev_q, prev_d;
    logic [9:0]     aligned_q, aligned_d;
    logic [3:0]     offset_q, offset_d;
    logic [RW-1:0]  run_q, run_d;
    logic [IW-1:0]  idle_q, idle_d;
    logic           skip_q, skip_d;
    logic [15:0]    loss_q, loss_d;
    logic [7:0]     data_q, data_d;
    logic           de_q, de_d;
    logic           c0_q, c0_d;
    logic           c1_q, c1_d;
    logic           locked_q, locked_d;

    logic [19:0]    window;
    logic [3:0]     offset_inc;
    logic           is_tok;
    logic [1:0]     tok_c;
    logic [7:0]     tword;
    logic [7:0]     dec_byte;

    // Stage 1: 20-bit window over two words, older word in the low half
    always_comb begin
        window    = {in_word, prev_q};
        prev_d    = in_word;
        aligned_d = 10'(window >> offset_q);
    end

    always_comb begin
        offset_inc = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
    end

    // Stage 2: control token recognition
    always_comb begin
        is_tok = 1'b1;
        tok_c  = 2'b00;
        case (aligned_q)
            TOK_00:  tok_c = 2'b00;
            TOK_01:  tok_c = 2'b01;
            TOK_10:  tok_c = 2'b10;
            TOK_11:  tok_c = 2'b11;
            default: is_tok = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain
    always_comb begin
        tword       = aligned_q[9] ? ~aligned_q[7:0] : aligned_q[7:0];
        dec_byte    = '0;
        dec_byte[0] = tword[0];
        for (int i = 1; i < 8; i++) begin
            if (aligned_q[8]) begin
                dec_byte[i] = tword[i] ^ tword[i-1];
            end else begin
                dec_byte[i] = ~(tword[i] ^ tword[i-1]);
            end
        end
    end

    // Alignment FSM; the word right after an offset change is stale
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        idle_d   = idle_q;
        offset_d = offset_q;
        skip_d   = 1'b0;
        loss_d   = loss_q;
        if (!skip_q) begin
            case (state_q)
                ST_SEARCH: begin
                    if (is_tok) begin
                        idle_d = '0;
                        if (run_q == LOCK_LAST) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        run_d = '0;
                        if (idle_q == SEARCH_LAST) begin
                            idle_d   = '0;
                            offset_d = offset_inc;
                            skip_d   = 1'b1;
                        end else begin
                            idle_d = idle_q + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (is_tok) begin
                        idle_d = '0;
                    end else if (idle_q == LOSS_LAST) begin
                        state_d  = ST_SEARCH;
                        idle_d   = '0;
                        run_d    = '0;
                        offset_d = offset_inc;
                        skip_d   = 1'b1;
                        if (loss_q != 16'hFFFF) begin
                            loss_d = loss_q + 16'd1;
                        end
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    // Output stage uses the state before this word's update
    always_comb begin
        locked_d = (state_q == ST_LOCKED);
        data_d   = 8'h00;
        de_d     = 1'b0;
        c0_d     = 1'b0;
        c1_d     = 1'b0;
        if (state_q == ST_LOCKED) begin
            if (is_tok) begin
                c0_d = tok_c[0];
                c1_d = tok_c[1];
            end else begin
                de_d   = 1'b1;
                data_d = dec_byte;
                c0_d   = c0_q;
                c1_d   = c1_q;
            end
        end
    end

    always_ff @(posedge clk_pixel or posedge rst_pixel) begin
        if (rst_pixel) begin
            state_q   <= ST_SEARCH;
            prev_q    <= '0;
            aligned_q <= '0;
            offset_q  <= '0;
            run_q     <= '0;
            idle_q    <= '0;
            skip_q    <= 1'b0;
            loss_q    <= '0;
            data_q    <= '0;
            de_q      <= 1'b0;
            c0_q      <= 1'b0;
            c1_q      <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            aligned_q <= aligned_d;
            offset_q  <= offset_d;
            run_q     <= run_d;
            idle_q    <= idle_d;
            skip_q    <= skip_d;
            loss_q    <= loss_d;
            data_q    <= data_d;
            de_q      <= de_d;
            c0_q      <= c0_d;
            c1_q      <= c1_d;
            locked_q  <= locked_d;
        end
    end

    assign out_data       = data_q;
    assign out_de         = de_q;
    assign out_c0         = c0_q;
    assign out_c1         = c1_q;
    assign out_locked     = locked_q;
    assign out_offset     = offset_q;
    assign out_loss_count = loss_q;

endmodule
